// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Parallel-side signal bundle of the UART receiver.
//   slave  : the receiver itself (takes serial_in/byte_read, drives results)
//   master : the board/host side (drives serial_in/byte_read, observes results)
// Signals:
//   serial_in   - asynchronous serial line, idle high
//   byte_read   - host acknowledge pulse, consumes the byte and clears flags
//   data_bus    - last accepted byte
//   byte_ready  - high while data_bus holds an unread byte
//   framing_err - sticky, a stop bit was sampled low
//   overrun_err - sticky, a valid frame arrived while byte_ready was high
interface uart_rx_if #(
  parameter int WORD_SIZE = 8
);
  logic                 serial_in;
  logic                 byte_read;
  logic [WORD_SIZE-1:0] data_bus;
  logic                 byte_ready;
  logic                 framing_err;
  logic                 overrun_err;

  modport master (
    output serial_in, byte_read,
    input  data_bus, byte_ready, framing_err, overrun_err
  );

  modport slave (
    input  serial_in, byte_read,
    output data_bus, byte_ready, framing_err, overrun_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
//   Oversampling UART receiver. Synchronizes the serial line, detects a
//   start bit, samples each bit at its middle, reassembles the LSB-first
//   word and hands it to the host with a ready/acknowledge handshake.
//   Framing and overrun conditions are reported as sticky flags.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - uart_rx_if.slave (serial_in, byte_read, data_bus, byte_ready,
//           framing_err, overrun_err)
// Parameters:
//   WORD_SIZE  - data bits per frame
//   OVERSAMPLE - clock cycles per serial bit (even, >= 4)
module uart_rx #(
  parameter int WORD_SIZE  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_next;
  logic                 sync1, sync2;
  logic                 rx_s;
  logic [1:0]           sync_valid;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_SIZE-1:0] shift;
  logic                 cnt_clear;
  logic                 take_bit;
  logic                 stop_sample;

  assign rx_s = sync2;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle sampling strobes. The counter is cleared
  // on every sample point so each state only has to watch for one value.
  always_comb begin
    state_next  = state;
    cnt_clear   = 1'b0;
    take_bit    = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_next = START;
          cnt_clear  = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_clear  = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_clear = 1'b1;
          take_bit  = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          stop_sample = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: synchronizer, arming, counters, shift register and host-side
  // outputs. The synchronizer resets to idle-high, so sync_valid holds off
  // arming until both flops carry real line samples; otherwise a line that
  // is low across reset release would look like a fresh start bit.
  // A host read is applied before the stop-bit result so that a read in the
  // same cycle frees the buffer, while a framing error still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1           <= 1'b1;
      sync2           <= 1'b1;
      sync_valid      <= 2'b00;
      armed           <= 1'b0;
      cnt             <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      bus.data_bus    <= '0;
      bus.byte_ready  <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.overrun_err <= 1'b0;
    end else begin
      sync1      <= bus.serial_in;
      sync2      <= sync1;
      sync_valid <= {sync_valid[0], 1'b1};

      if (stop_sample) begin
        armed <= 1'b0;
      end else if (sync_valid[1] && rx_s) begin
        armed <= 1'b1;
      end

      if (cnt_clear) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (state == START) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (take_bit) begin
        shift <= {rx_s, shift[WORD_SIZE-1:1]};
      end

      if (bus.byte_read) begin
        bus.byte_ready  <= 1'b0;
        bus.framing_err <= 1'b0;
        bus.overrun_err <= 1'b0;
      end

      if (stop_sample) begin
        if (!rx_s) begin
          bus.framing_err <= 1'b1;
        end else if (bus.byte_ready && !bus.byte_read) begin
          bus.overrun_err <= 1'b1;
        end else begin
          bus.data_bus   <= shift;
          bus.byte_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Self-checking bench for uart_rx. Frames are generated bit by bit on the
//   serial line; a reference model of the host-visible registers is updated
//   from the frame contents and compared at the stop-sample edge.
module tb_uart_rx;

  localparam int W  = 8;
  localparam int OS = 8;
  // Loop iteration whose following rising edge is the stop-bit sample edge:
  // start falls before edge 1, FSM sees it at edge 3, stop sampled
  // OS/2 + (W+1)*OS edges later.
  localparam int C_STOP = 2 + OS / 2 + (W + 1) * OS;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  logic [W-1:0] m_data;
  logic         m_ready;
  logic         m_fe;
  logic         m_oe;

  uart_rx_if #(.WORD_SIZE(W)) bus ();

  uart_rx #(.WORD_SIZE(W), .OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".data"},  32'(bus.data_bus),    32'(m_data));
    check({tag, ".ready"}, 32'(bus.byte_ready),  32'(m_ready));
    check({tag, ".ferr"},  32'(bus.framing_err), 32'(m_fe));
    check({tag, ".oerr"},  32'(bus.overrun_err), 32'(m_oe));
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_oe    = 1'b0;
  endtask

  // Host-visible effect of one completed frame with optional same-edge read.
  task automatic model_frame(input logic [W-1:0] b, input logic stop_bit, input logic rd);
    if (rd) begin
      m_ready = 1'b0;
      m_fe    = 1'b0;
      m_oe    = 1'b0;
    end
    if (!stop_bit) begin
      m_fe = 1'b1;
    end else if (m_ready) begin
      m_oe = 1'b1;
    end else begin
      m_data  = b;
      m_ready = 1'b1;
    end
  endtask

  // Sends one full frame starting at a falling edge; checks outputs one edge
  // before and exactly on the stop-sample edge.
  task automatic send_frame(input logic [W-1:0] b, input logic stop_bit, input logic rd,
                            input string tag);
    for (int c = 0; c < (W + 2) * OS; c++) begin
      int bitn;
      bitn = c / OS;
      if (bitn == 0) begin
        bus.serial_in = 1'b0;
      end else if (bitn <= W) begin
        bus.serial_in = b[bitn-1];
      end else begin
        bus.serial_in = stop_bit;
      end
      bus.byte_read = rd && (c == C_STOP);
      @(negedge clk);
      if (c == C_STOP - 1) begin
        check_output({tag, ".pre"});
      end
      if (c == C_STOP) begin
        model_frame(b, stop_bit, rd);
        check_output({tag, ".stop"});
      end
    end
    bus.byte_read = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_pulse(input string tag);
    bus.byte_read = 1'b1;
    @(negedge clk);
    bus.byte_read = 1'b0;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_oe    = 1'b0;
    check_output(tag);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.serial_in = 1'b1;
    bus.byte_read = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("reset");
    rst_n = 1'b1;
    idle_cycles(6);
    check_output("idle");

    // Basic frame with exact stop-edge timing, then acknowledge.
    send_frame(8'hA5, 1'b1, 1'b0, "a5");
    idle_cycles(4);
    read_pulse("a5_read");

    // Short low glitch on the line must not start a frame.
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    idle_cycles(20);
    check_output("glitch");
    send_frame(8'h5A, 1'b1, 1'b0, "5a");
    idle_cycles(2);
    read_pulse("5a_read");

    // Framing error, one bit time of idle, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, "3c_ferr");
    idle_cycles(OS);
    check_output("ferr_hold");
    send_frame(8'h0F, 1'b1, 1'b0, "0f");
    idle_cycles(2);
    read_pulse("0f_read");

    // Back-to-back frames without a read: overrun.
    send_frame(8'h11, 1'b1, 1'b0, "11");
    send_frame(8'h22, 1'b1, 1'b0, "22_ovr");
    idle_cycles(2);
    read_pulse("ovr_read");

    // Read on the stop-sample edge of the second frame: no overrun.
    send_frame(8'h11, 1'b1, 1'b0, "11b");
    send_frame(8'h22, 1'b1, 1'b1, "22_rd");
    idle_cycles(2);
    read_pulse("22_read");

    // Reset in the middle of a frame with the line held low through release.
    bus.serial_in = 1'b0;
    repeat (OS) @(negedge clk);
    bus.serial_in = 1'b1;
    repeat (3 * OS) @(negedge clk);
    bus.serial_in = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * OS) @(negedge clk);
    check_output("break_after_reset");
    idle_cycles(OS);
    send_frame(8'hC3, 1'b1, 1'b0, "c3");
    idle_cycles(2);
    read_pulse("c3_read");

    // Randomized frames against the model.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] b;
      logic         sb;
      logic         rd;
      int           gap;
      b   = W'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      rd  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 6);
      send_frame(b, sb, rd, "rand");
      if (!sb && gap < OS) begin
        gap = OS;
      end
      if (gap > 0) begin
        idle_cycles(gap);
      end
      if ($urandom_range(0, 2) == 0) begin
        read_pulse("rand_read");
      end
    end
    idle_cycles(4);
    check_output("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
